rvc_decode_stage: RTL and testbench

Registered decode stage for 16-bit RV32EC compressed instructions. It consumes one halfword per valid/ready transfer and expands it into a base-ISA operation class, register indices and a sign-extended 32-bit immediate, so the execute stage never sees compressed encodings. It is the consumer side of the compressed-instruction stream produced by the instruction ROM. It also maintains a saturating illegal-instruction counter for debug.

---
 rtl/rvc_pkg.sv | 74 +++++++
 rtl/rvc_expand.sv | 218 +++++++++++++++++++++
 rtl/rvc_decode_stage.sv | 98 +++++++++
 tb/tb_rvc_decode_stage.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvc_pkg.sv
// Shared types and constants for the RV32EC compressed-instruction decode stage.
//   op_e       : base-ISA operation class handed to execute
//   decoded_t  : expanded instruction fields (op, rd, rs1, rs2, imm)
//   Quad*/F3*  : quadrant and funct3 encodings of the compressed ISA
//   reg_ok()   : RV32E register-field check (x0..x15 only)
package rvc_pkg;

  typedef enum logic [4:0] {
    OP_ADDI,
    OP_ANDI,
    OP_SLLI,
    OP_SRLI,
    OP_SRAI,
    OP_ADD,
    OP_SUB,
    OP_XOR,
    OP_OR,
    OP_AND,
    OP_LUI,
    OP_JAL,
    OP_JALR,
    OP_BEQ,
    OP_BNE,
    OP_LW,
    OP_SW,
    OP_EBREAK,
    OP_ILLEGAL
  } op_e;

  typedef struct packed {
    op_e         op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] imm;
  } decoded_t;

  // Value of an illegal or reset entry: every field zero, class OP_ILLEGAL.
  localparam decoded_t DecIllegal = '{op: OP_ILLEGAL, rd: 4'd0, rs1: 4'd0, rs2: 4'd0,
                                      imm: 32'd0};

  // Quadrants (instr[1:0])
  localparam logic [1:0] QuadC0   = 2'b00;
  localparam logic [1:0] QuadC1   = 2'b01;
  localparam logic [1:0] QuadC2   = 2'b10;
  localparam logic [1:0] QuadRv32 = 2'b11;

  // Quadrant 0 funct3 (instr[15:13])
  localparam logic [2:0] F3Addi4spn = 3'b000;
  localparam logic [2:0] F3Lw       = 3'b010;
  localparam logic [2:0] F3Sw       = 3'b110;

  // Quadrant 1 funct3
  localparam logic [2:0] F3Addi = 3'b000;
  localparam logic [2:0] F3Jal  = 3'b001;
  localparam logic [2:0] F3Li   = 3'b010;
  localparam logic [2:0] F3Lui  = 3'b011;
  localparam logic [2:0] F3Alu  = 3'b100;
  localparam logic [2:0] F3J    = 3'b101;
  localparam logic [2:0] F3Beqz = 3'b110;
  localparam logic [2:0] F3Bnez = 3'b111;

  // Quadrant 2 funct3
  localparam logic [2:0] F3Slli     = 3'b000;
  localparam logic [2:0] F3Lwsp     = 3'b010;
  localparam logic [2:0] F3JrMvAdd  = 3'b100;
  localparam logic [2:0] F3Swsp     = 3'b110;

  // RV32E has only x0..x15, so a full 5-bit field with bit 4 set is illegal.
  function automatic logic reg_ok(logic [4:0] r);
    return !r[4];
  endfunction

endpackage

// File: rtl/rvc_expand.sv
// Purely combinational expander: 16-bit compressed instruction -> decoded_t + illegal flag.
//   instr_i   : compressed instruction
//   dec_o     : expanded fields (all zero with OP_ILLEGAL when illegal)
//   illegal_o : instruction is illegal / unsupported
// Configuration macro RVC_MEM_OPS_EN: when defined, c.lw, c.sw, c.lwsp, c.swsp and
// c.addi4spn are decoded; otherwise those encodings fall through to illegal.
module rvc_expand
  import rvc_pkg::*;
(
  input  logic [15:0] instr_i,
  output decoded_t    dec_o,
  output logic        illegal_o
);

  logic [1:0]  quad;
  logic [2:0]  f3;
  logic [3:0]  crs1;    // rs1'/rd' at [9:7]
  logic [3:0]  crs2;    // rs2'/rd' at [4:2]
  logic [31:0] imm6;    // sign-extended {instr[12], instr[6:2]}
  logic [31:0] jimm;
  logic [31:0] bimm;
  decoded_t    dec;
  logic        ill;

  assign quad = instr_i[1:0];
  assign f3   = instr_i[15:13];
  assign crs1 = {1'b1, instr_i[9:7]};
  assign crs2 = {1'b1, instr_i[4:2]};
  assign imm6 = {{26{instr_i[12]}}, instr_i[12], instr_i[6:2]};
  assign jimm = {{20{instr_i[12]}}, instr_i[12], instr_i[8], instr_i[10:9], instr_i[6],
                 instr_i[7], instr_i[2], instr_i[11], instr_i[5:3], 1'b0};
  assign bimm = {{23{instr_i[12]}}, instr_i[12], instr_i[6:5], instr_i[2], instr_i[11:10],
                 instr_i[4:3], 1'b0};

  always_comb begin
    dec    = '0;
    dec.op = OP_ILLEGAL;
    ill    = 1'b0;
    unique case (quad)
      QuadC0: begin
        unique case (f3)
`ifdef RVC_MEM_OPS_EN
          F3Addi4spn: begin
            dec.op  = OP_ADDI;
            dec.rd  = crs2;
            dec.rs1 = 4'd2;
            dec.imm = {22'd0, instr_i[10:7], instr_i[12:11], instr_i[5], instr_i[6], 2'b00};
            ill     = (instr_i[12:5] == 8'd0);
          end
          F3Lw: begin
            dec.op  = OP_LW;
            dec.rd  = crs2;
            dec.rs1 = crs1;
            dec.imm = {25'd0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00};
          end
          F3Sw: begin
            dec.op  = OP_SW;
            dec.rs1 = crs1;
            dec.rs2 = crs2;
            dec.imm = {25'd0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00};
          end
`endif
          default: ill = 1'b1;
        endcase
      end

      QuadC1: begin
        unique case (f3)
          F3Addi: begin
            dec.op  = OP_ADDI;
            dec.rd  = instr_i[10:7];
            dec.rs1 = instr_i[10:7];
            dec.imm = imm6;
            ill     = !reg_ok(instr_i[11:7]);
          end
          F3Jal: begin
            dec.op  = OP_JAL;
            dec.rd  = 4'd1;
            dec.imm = jimm;
          end
          F3Li: begin
            dec.op  = OP_ADDI;
            dec.rd  = instr_i[10:7];
            dec.imm = imm6;
            ill     = !reg_ok(instr_i[11:7]);
          end
          F3Lui: begin
            if (instr_i[11:7] == 5'd2) begin
              // c.addi16sp shares the c.lui encoding with rd = x2
              dec.op  = OP_ADDI;
              dec.rd  = 4'd2;
              dec.rs1 = 4'd2;
              dec.imm = {{22{instr_i[12]}}, instr_i[12], instr_i[4:3], instr_i[5], instr_i[2],
                         instr_i[6], 4'b0000};
              ill     = ({instr_i[12], instr_i[6:2]} == 6'd0);
            end else begin
              dec.op  = OP_LUI;
              dec.rd  = instr_i[10:7];
              dec.imm = {{14{instr_i[12]}}, instr_i[12], instr_i[6:2], 12'd0};
              ill     = !reg_ok(instr_i[11:7]) || ({instr_i[12], instr_i[6:2]} == 6'd0);
            end
          end
          F3Alu: begin
            dec.rd  = crs1;
            dec.rs1 = crs1;
            unique case (instr_i[11:10])
              2'b00: begin
                dec.op  = OP_SRLI;
                dec.imm = {27'd0, instr_i[6:2]};
                ill     = instr_i[12];
              end
              2'b01: begin
                dec.op  = OP_SRAI;
                dec.imm = {27'd0, instr_i[6:2]};
                ill     = instr_i[12];
              end
              2'b10: begin
                dec.op  = OP_ANDI;
                dec.imm = imm6;
              end
              default: begin
                dec.rs2 = crs2;
                // instr[12] = 1 selects RV64-only / reserved register ops
                ill     = instr_i[12];
                unique case (instr_i[6:5])
                  2'b00:   dec.op = OP_SUB;
                  2'b01:   dec.op = OP_XOR;
                  2'b10:   dec.op = OP_OR;
                  default: dec.op = OP_AND;
                endcase
              end
            endcase
          end
          F3J: begin
            dec.op  = OP_JAL;
            dec.imm = jimm;
          end
          F3Beqz: begin
            dec.op  = OP_BEQ;
            dec.rs1 = crs1;
            dec.imm = bimm;
          end
          default: begin
            dec.op  = OP_BNE;
            dec.rs1 = crs1;
            dec.imm = bimm;
          end
        endcase
      end

      QuadC2: begin
        unique case (f3)
          F3Slli: begin
            dec.op  = OP_SLLI;
            dec.rd  = instr_i[10:7];
            dec.rs1 = instr_i[10:7];
            dec.imm = {27'd0, instr_i[6:2]};
            ill     = instr_i[12] || !reg_ok(instr_i[11:7]);
          end
`ifdef RVC_MEM_OPS_EN
          F3Lwsp: begin
            dec.op  = OP_LW;
            dec.rd  = instr_i[10:7];
            dec.rs1 = 4'd2;
            dec.imm = {24'd0, instr_i[3:2], instr_i[12], instr_i[6:4], 2'b00};
            ill     = !reg_ok(instr_i[11:7]) || (instr_i[11:7] == 5'd0);
          end
          F3Swsp: begin
            dec.op  = OP_SW;
            dec.rs1 = 4'd2;
            dec.rs2 = instr_i[5:2];
            dec.imm = {24'd0, instr_i[8:7], instr_i[12:9], 2'b00};
            ill     = !reg_ok(instr_i[6:2]);
          end
`endif
          F3JrMvAdd: begin
            if (!instr_i[12]) begin
              if (instr_i[6:2] == 5'd0) begin
                dec.op  = OP_JALR;
                dec.rs1 = instr_i[10:7];
                ill     = !reg_ok(instr_i[11:7]) || (instr_i[11:7] == 5'd0);
              end else begin
                dec.op  = OP_ADD;
                dec.rd  = instr_i[10:7];
                dec.rs2 = instr_i[5:2];
                ill     = !reg_ok(instr_i[11:7]) || !reg_ok(instr_i[6:2]);
              end
            end else if (instr_i[11:2] == 10'd0) begin
              dec.op = OP_EBREAK;
            end else if (instr_i[6:2] == 5'd0) begin
              dec.op  = OP_JALR;
              dec.rd  = 4'd1;
              dec.rs1 = instr_i[10:7];
              ill     = !reg_ok(instr_i[11:7]);
            end else begin
              dec.op  = OP_ADD;
              dec.rd  = instr_i[10:7];
              dec.rs1 = instr_i[10:7];
              dec.rs2 = instr_i[5:2];
              ill     = !reg_ok(instr_i[11:7]) || !reg_ok(instr_i[6:2]);
            end
          end
          default: ill = 1'b1;
        endcase
      end

      default: ill = 1'b1;  // QuadRv32: 32-bit encodings are not handled here
    endcase

    if (ill) begin
      dec = DecIllegal;
    end
  end

  assign dec_o     = dec;
  assign illegal_o = ill;

endmodule

// File: rtl/rvc_decode_stage.sv
// Registered decode stage for RV32EC compressed instructions (one halfword per transfer).
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   flush_i              : drop the held entry (wins over a same-cycle accept)
//   in_valid_i/in_ready_o, in_instr_i, in_pc_i : upstream valid/ready channel
//   out_valid_o/out_ready_i, out_op_o, out_rd_o, out_rs1_o, out_rs2_o, out_imm_o,
//   out_pc_o, out_illegal_o : downstream decoded entry
//   illegal_count_o      : saturating count of accepted illegal instructions
// Configuration macro RVC_MEM_OPS_EN (see rvc_expand) enables the memory-op encodings.
module rvc_decode_stage
  import rvc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] in_instr_i,
  input  logic [31:0] in_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output op_e         out_op_o,
  output logic [3:0]  out_rd_o,
  output logic [3:0]  out_rs1_o,
  output logic [3:0]  out_rs2_o,
  output logic [31:0] out_imm_o,
  output logic [31:0] out_pc_o,
  output logic        out_illegal_o,
  output logic [15:0] illegal_count_o
);

  decoded_t    exp_dec;
  logic        exp_ill;
  logic        accept;

  logic        valid_d, valid_q;
  decoded_t    entry_d, entry_q;
  logic [31:0] pc_d, pc_q;
  logic        ill_d, ill_q;
  logic [15:0] count_d, count_q;

  rvc_expand u_expand (
    .instr_i   (in_instr_i),
    .dec_o     (exp_dec),
    .illegal_o (exp_ill)
  );

  assign in_ready_o = !valid_q || out_ready_i;
  // A flushed transfer is not an accept: nothing loads and nothing is counted.
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    pc_d    = pc_q;
    ill_d   = ill_q;
    count_d = count_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      entry_d = exp_dec;
      pc_d    = in_pc_i;
      ill_d   = exp_ill;
      if (exp_ill && (count_q != 16'hFFFF)) begin
        count_d = count_q + 16'd1;
      end
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      entry_q <= DecIllegal;
      pc_q    <= 32'd0;
      ill_q   <= 1'b0;
      count_q <= 16'd0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
      pc_q    <= pc_d;
      ill_q   <= ill_d;
      count_q <= count_d;
    end
  end

  assign out_valid_o     = valid_q;
  assign out_op_o        = entry_q.op;
  assign out_rd_o        = entry_q.rd;
  assign out_rs1_o       = entry_q.rs1;
  assign out_rs2_o       = entry_q.rs2;
  assign out_imm_o       = entry_q.imm;
  assign out_pc_o        = pc_q;
  assign out_illegal_o   = ill_q;
  assign illegal_count_o = count_q;

endmodule

// File: tb/tb_rvc_decode_stage.sv
// Self-checking bench for rvc_decode_stage: directed vector table, handshake corner
// sequences, and randomized traffic scored against a behavioural decode model.
module tb_rvc_decode_stage;
  import rvc_pkg::*;

`ifdef RVC_MEM_OPS_EN
  localparam bit MemOps = 1'b1;
`else
  localparam bit MemOps = 1'b0;
`endif

  typedef struct {
    int          op;
    int          rd;
    int          rs1;
    int          rs2;
    logic [31:0] imm;
    bit          ill;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [15:0] instr;
    exp_t        e;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  op_e         out_op;
  logic [3:0]  out_rd;
  logic [3:0]  out_rs1;
  logic [3:0]  out_rs2;
  logic [31:0] out_imm;
  logic [31:0] out_pc;
  logic        out_illegal;
  logic [15:0] illegal_count;

  int n_tests = 0;
  int n_fail  = 0;

  rvc_decode_stage dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_instr_i      (in_instr),
    .in_pc_i         (in_pc),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_op_o        (out_op),
    .out_rd_o        (out_rd),
    .out_rs1_o       (out_rs1),
    .out_rs2_o       (out_rs2),
    .out_imm_o       (out_imm),
    .out_pc_o        (out_pc),
    .out_illegal_o   (out_illegal),
    .illegal_count_o (illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic check_entry(input string name, input exp_t e);
    check({name, ".valid"}, 32'(out_valid), 32'd1);
    check({name, ".op"}, 32'(int'(out_op)), 32'(e.op));
    check({name, ".rd"}, 32'(out_rd), 32'(e.rd));
    check({name, ".rs1"}, 32'(out_rs1), 32'(e.rs1));
    check({name, ".rs2"}, 32'(out_rs2), 32'(e.rs2));
    check({name, ".imm"}, out_imm, e.imm);
    check({name, ".illegal"}, 32'(out_illegal), 32'(e.ill));
    check({name, ".pc"}, out_pc, e.pc);
  endtask

  task automatic check_reset_state(input string name);
    check({name, ".valid"}, 32'(out_valid), 32'd0);
    check({name, ".op"}, 32'(int'(out_op)), 32'(int'(OP_ILLEGAL)));
    check({name, ".rd"}, 32'(out_rd), 32'd0);
    check({name, ".rs1"}, 32'(out_rs1), 32'd0);
    check({name, ".rs2"}, 32'(out_rs2), 32'd0);
    check({name, ".imm"}, out_imm, 32'd0);
    check({name, ".pc"}, out_pc, 32'd0);
    check({name, ".illegal"}, 32'(out_illegal), 32'd0);
    check({name, ".count"}, 32'(illegal_count), 32'd0);
    check({name, ".in_ready"}, 32'(in_ready), 32'd1);
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int fld(input logic [15:0] x, input int hi, input int lo);
    int v;
    v = int'(x);
    return (v >> lo) & ((1 << (hi - lo + 1)) - 1);
  endfunction

  function automatic int sext(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  function automatic exp_t model(input logic [15:0] x);
    exp_t e;
    int q, f3, r1, r2, rp1, rp2, imm6, hi, u;
    bit ok;
    e  = '{op: int'(OP_ILLEGAL), rd: 0, rs1: 0, rs2: 0, imm: 32'd0, ill: 1'b0, pc: 32'd0};
    ok = 1'b0;
    q    = fld(x, 1, 0);
    f3   = fld(x, 15, 13);
    r1   = fld(x, 11, 7);
    r2   = fld(x, 6, 2);
    rp1  = 8 + fld(x, 9, 7);
    rp2  = 8 + fld(x, 4, 2);
    hi   = fld(x, 12, 12);
    imm6 = sext(hi * 32 + r2, 6);
    if (q == 0) begin
      if (f3 == 0) begin
        u = fld(x, 10, 7) * 64 + fld(x, 12, 11) * 16 + fld(x, 5, 5) * 8 + fld(x, 6, 6) * 4;
        ok = MemOps && (u != 0);
        e.op = int'(OP_ADDI); e.rd = rp2; e.rs1 = 2; e.imm = 32'(u);
      end else if (f3 == 2 || f3 == 6) begin
        u = fld(x, 5, 5) * 64 + fld(x, 12, 10) * 8 + fld(x, 6, 6) * 4;
        ok = MemOps;
        e.rs1 = rp1; e.imm = 32'(u);
        if (f3 == 2) begin e.op = int'(OP_LW); e.rd = rp2; end
        else begin e.op = int'(OP_SW); e.rs2 = rp2; end
      end
    end else if (q == 1) begin
      case (f3)
        0: begin ok = r1 < 16; e.op = int'(OP_ADDI); e.rd = r1; e.rs1 = r1; e.imm = 32'(imm6); end
        1, 5: begin
          u = hi * 2048 + fld(x, 8, 8) * 1024 + fld(x, 10, 9) * 256 + fld(x, 6, 6) * 128
            + fld(x, 7, 7) * 64 + fld(x, 2, 2) * 32 + fld(x, 11, 11) * 16 + fld(x, 5, 3) * 2;
          ok = 1'b1; e.op = int'(OP_JAL); e.rd = (f3 == 1) ? 1 : 0; e.imm = 32'(sext(u, 12));
        end
        2: begin ok = r1 < 16; e.op = int'(OP_ADDI); e.rd = r1; e.imm = 32'(imm6); end
        3: begin
          if (r1 == 2) begin
            u = hi * 512 + fld(x, 4, 3) * 128 + fld(x, 5, 5) * 64 + fld(x, 2, 2) * 32
              + fld(x, 6, 6) * 16;
            ok = u != 0; e.op = int'(OP_ADDI); e.rd = 2; e.rs1 = 2; e.imm = 32'(sext(u, 10));
          end else begin
            ok = (r1 < 16) && (imm6 != 0); e.op = int'(OP_LUI); e.rd = r1;
            e.imm = 32'(imm6 * 4096);
          end
        end
        4: begin
          e.rd = rp1; e.rs1 = rp1;
          case (fld(x, 11, 10))
            0: begin ok = hi == 0; e.op = int'(OP_SRLI); e.imm = 32'(r2); end
            1: begin ok = hi == 0; e.op = int'(OP_SRAI); e.imm = 32'(r2); end
            2: begin ok = 1'b1; e.op = int'(OP_ANDI); e.imm = 32'(imm6); end
            default: begin
              ok = hi == 0; e.rs2 = rp2;
              case (fld(x, 6, 5))
                0: e.op = int'(OP_SUB);
                1: e.op = int'(OP_XOR);
                2: e.op = int'(OP_OR);
                default: e.op = int'(OP_AND);
              endcase
            end
          endcase
        end
        default: begin
          u = hi * 256 + fld(x, 6, 5) * 64 + fld(x, 2, 2) * 32 + fld(x, 11, 10) * 8
            + fld(x, 4, 3) * 2;
          ok = 1'b1; e.op = (f3 == 6) ? int'(OP_BEQ) : int'(OP_BNE); e.rs1 = rp1;
          e.imm = 32'(sext(u, 9));
        end
      endcase
    end else if (q == 2) begin
      if (f3 == 0) begin
        ok = (hi == 0) && (r1 < 16); e.op = int'(OP_SLLI); e.rd = r1; e.rs1 = r1;
        e.imm = 32'(r2);
      end else if (f3 == 2) begin
        u = fld(x, 3, 2) * 64 + hi * 32 + fld(x, 6, 4) * 4;
        ok = MemOps && (r1 != 0) && (r1 < 16); e.op = int'(OP_LW); e.rd = r1; e.rs1 = 2;
        e.imm = 32'(u);
      end else if (f3 == 6) begin
        u = fld(x, 8, 7) * 64 + fld(x, 12, 9) * 4;
        ok = MemOps && (r2 < 16); e.op = int'(OP_SW); e.rs1 = 2; e.rs2 = r2; e.imm = 32'(u);
      end else if (f3 == 4) begin
        if (hi == 0 && r2 == 0) begin
          ok = (r1 != 0) && (r1 < 16); e.op = int'(OP_JALR); e.rs1 = r1;
        end else if (hi == 0) begin
          ok = (r1 < 16) && (r2 < 16); e.op = int'(OP_ADD); e.rd = r1; e.rs2 = r2;
        end else if (r1 == 0 && r2 == 0) begin
          ok = 1'b1; e.op = int'(OP_EBREAK);
        end else if (r2 == 0) begin
          ok = r1 < 16; e.op = int'(OP_JALR); e.rd = 1; e.rs1 = r1;
        end else begin
          ok = (r1 < 16) && (r2 < 16); e.op = int'(OP_ADD); e.rd = r1; e.rs1 = r1; e.rs2 = r2;
        end
      end
    end
    if (!ok) begin
      e = '{op: int'(OP_ILLEGAL), rd: 0, rs1: 0, rs2: 0, imm: 32'd0, ill: 1'b1, pc: 32'd0};
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic [15:0] instr, input op_e op, input int rd,
                              input int rs1, input int rs2, input logic [31:0] imm,
                              input bit ill);
    vec_t v;
    v.instr = instr;
    v.e     = '{op: int'(op), rd: rd, rs1: rs1, rs2: rs2, imm: imm, ill: ill, pc: 32'd0};
    return v;
  endfunction

  // ---------------- test sequence ----------------
  vec_t vecs[$];
  exp_t sb[$];
  exp_t tmp;
  int   exp_count;
  int   table_ill;
  logic [15:0] count_snap;
  logic [15:0] rnd_instr;
  bit   mdl_ready;

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 16'h0;
    in_pc     = 32'h0;
    out_ready = 1'b1;

    vecs.push_back(mk(16'h4705, OP_ADDI, 14, 0, 0, 32'h1, 1'b0));
    vecs.push_back(mk(16'h97BA, OP_ADD, 15, 15, 14, 32'h0, 1'b0));
    vecs.push_back(mk(16'h0705, OP_ADDI, 14, 14, 0, 32'h1, 1'b0));
    vecs.push_back(mk(16'h0792, OP_SLLI, 15, 15, 0, 32'h4, 1'b0));
    vecs.push_back(mk(16'h577D, OP_ADDI, 14, 0, 0, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(16'hBFFD, OP_JAL, 0, 0, 0, 32'hFFFF_FFFE, 1'b0));
    vecs.push_back(mk(16'h0000, OP_ILLEGAL, 0, 0, 0, 32'h0, 1'b1));
    vecs.push_back(mk(16'h4801, OP_ILLEGAL, 0, 0, 0, 32'h0, 1'b1));
    vecs.push_back(mk(16'h0003, OP_ILLEGAL, 0, 0, 0, 32'h0, 1'b1));
    vecs.push_back(mk(16'h6785, OP_LUI, 15, 0, 0, 32'h0000_1000, 1'b0));
    vecs.push_back(mk(16'h7785, OP_LUI, 15, 0, 0, 32'hFFFE_1000, 1'b0));
    vecs.push_back(mk(16'h8002, OP_ILLEGAL, 0, 0, 0, 32'h0, 1'b1));
    vecs.push_back(mk(16'h9002, OP_EBREAK, 0, 0, 0, 32'h0, 1'b0));
    vecs.push_back(mk(16'h9005, OP_ILLEGAL, 0, 0, 0, 32'h0, 1'b1));
`ifdef RVC_MEM_OPS_EN
    vecs.push_back(mk(16'h4398, OP_LW, 14, 15, 0, 32'h0, 1'b0));
`else
    vecs.push_back(mk(16'h4398, OP_ILLEGAL, 0, 0, 0, 32'h0, 1'b1));
`endif
    table_ill = 0;
    foreach (vecs[i]) begin
      vecs[i].e.pc = 32'h1000 + 32'(2 * i);
      if (vecs[i].e.ill) table_ill++;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1 check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, back to back with out_ready high: vector i is visible one cycle later
    for (int i = 0; i <= vecs.size(); i++) begin
      @(posedge clk);
      #1;
      if (i < vecs.size()) begin
        in_valid = 1'b1;
        in_instr = vecs[i].instr;
        in_pc    = vecs[i].e.pc;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i > 0) check_entry($sformatf("vec%0d_%04h", i - 1, vecs[i - 1].instr), vecs[i - 1].e);
    end
    @(negedge clk);
    check("table.drained", 32'(out_valid), 32'd0);
    check("table.ill_count", 32'(illegal_count), 32'(table_ill));
    exp_count = table_ill;

    // Backpressure: A held while B waits three cycles, then both move exactly once
    @(posedge clk);
    #1 in_valid = 1'b1; in_instr = 16'h4705; in_pc = 32'h100; out_ready = 1'b0;
    @(posedge clk);
    #1 in_instr = 16'h0705; in_pc = 32'h102;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tmp = model(16'h4705);
      tmp.pc = 32'h100;
      check($sformatf("stall%0d.in_ready", k), 32'(in_ready), 32'd0);
      check_entry($sformatf("stall%0d", k), tmp);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("release.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    tmp = '{op: int'(OP_ADDI), rd: 14, rs1: 14, rs2: 0, imm: 32'h1, ill: 1'b0, pc: 32'h102};
    check_entry("release.B", tmp);
    @(negedge clk);
    check("release.once", 32'(out_valid), 32'd0);

    // Flush wins over a same-cycle accept of an illegal instruction
    @(posedge clk);
    #1 in_valid = 1'b1; in_instr = 16'h4705; in_pc = 32'h200; out_ready = 1'b0;
    @(posedge clk);
    #1 in_instr = 16'h0000; in_pc = 32'h202; out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush.pre_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush.valid", 32'(out_valid), 32'd0);
    check("flush.count", 32'(illegal_count), 32'(exp_count));

    // Randomized traffic against the model, with a one-deep scoreboard
    sb.delete();
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      rnd_instr = 16'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        rnd_instr[11] = 1'b0;
        rnd_instr[6]  = 1'b0;
      end
      if (rnd_instr[1:0] == 2'b11 && $urandom_range(3, 0) != 0)
        rnd_instr[1:0] = 2'($urandom_range(2, 0));
      in_valid  = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(2, 0) != 0);
      flush     = ($urandom_range(31, 0) == 0);
      in_instr  = rnd_instr;
      in_pc     = $urandom;
      @(negedge clk);
      check("rnd.valid", 32'(out_valid), 32'(sb.size() != 0));
      check("rnd.count", 32'(illegal_count), 32'(exp_count));
      mdl_ready = (sb.size() == 0) || out_ready;
      check("rnd.in_ready", 32'(in_ready), 32'(mdl_ready));
      if (sb.size() != 0 && out_ready && !flush) check_entry("rnd", sb[0]);
      if (flush) begin
        sb.delete();
      end else begin
        if (sb.size() != 0 && out_ready) void'(sb.pop_front());
        if (in_valid && mdl_ready) begin
          tmp    = model(in_instr);
          tmp.pc = in_pc;
          sb.push_back(tmp);
          if (tmp.ill && exp_count < 16'hFFFF) exp_count++;
        end
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

    // Reset mid-stream with an entry held and a nonzero count
    @(posedge clk);
    #1 in_valid = 1'b1; in_instr = 16'h0000; in_pc = 32'h300;
    @(posedge clk);
    #1 in_instr = 16'h4705;
    @(negedge clk);
    check("midrst.pre_valid", 32'(out_valid), 32'd1);
    check("midrst.pre_count_nz", 32'(illegal_count != 16'd0), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_state("midrst");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("midrst.after_valid", 32'(out_valid), 32'd0);
    count_snap = illegal_count;
    check("midrst.after_count", 32'(count_snap), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
